uart_rx_axis: RTL and testbench



---
 rtl/uart_rx_axis.sv | 115 +++++++++++
 tb/tb_uart_rx_axis.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: 8N1 UART receiver to AXI-Stream with framing/overrun flags; define UART_RX_PARITY_EN for even parity
module uart_rx_axis #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 1000000,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] m_data_tdata,
  output logic                  m_data_tvalid,
  input  logic                  m_data_tready,
  output logic                  frame_err,
  output logic                  overrun
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  logic par_bad, par_n;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif
  state_t state, state_n;
  logic rx_m, rx_s, tick, done, load, ferr_n;
  logic [CW-1:0] clk_cnt, clk_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shreg, sh_n;
  assign tick = clk_cnt == (state == START ? HALF : FULL);
  assign load = done & (~m_data_tvalid | m_data_tready);
  always_comb begin
    state_n = state;
    clk_n   = tick ? '0 : clk_cnt + 1'b1;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    done    = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bad;
`endif
    unique case (state)
      IDLE: begin
        clk_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (tick) state_n = rx_s ? IDLE : DATA;
      DATA: if (tick) begin
        sh_n  = {rx_s, shreg[DATA_WIDTH-1:1]};
        bit_n = bit_cnt == LAST ? '0 : bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt == LAST) state_n = PARITY;
`else
        if (bit_cnt == LAST) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_n   = ^shreg ^ rx_s;
        state_n = STOP;
      end
      STOP: if (tick) begin
        state_n = rx_s ? IDLE : WAIT_IDLE;
        done    = rx_s & ~par_bad;
        ferr_n  = ~rx_s | par_bad;
      end
`else
      STOP: if (tick) begin
        state_n = rx_s ? IDLE : WAIT_IDLE;
        done    = rx_s;
        ferr_n  = ~rx_s;
      end
`endif
      WAIT_IDLE: begin
        clk_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (arst) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      m_data_tdata  <= '0;
      m_data_tvalid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad       <= 1'b0;
`endif
    end else begin
      rx_m          <= rx;
      rx_s          <= rx_m;
      state         <= state_n;
      clk_cnt       <= clk_n;
      bit_cnt       <= bit_n;
      shreg         <= sh_n;
      frame_err     <= ferr_n;
      overrun       <= done & m_data_tvalid & ~m_data_tready;
      m_data_tvalid <= load | (m_data_tvalid & ~m_data_tready);
      if (load) m_data_tdata <= shreg;
`ifdef UART_RX_PARITY_EN
      par_bad       <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: randomized frames checked against a queue-based model of the receiver
module tb_uart_rx_axis;
  localparam int CPB = 100;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic aclk = 1'b0, arst = 1'b1, rx = 1'b1, tready = 1'b1;
  logic [7:0] tdata;
  logic tvalid, ferr, ovr;
  uart_rx_axis #(.CLK_FREQ(100000000), .BAUD(1000000), .DATA_WIDTH(8)) dut (
    .aclk(aclk), .arst(arst), .rx(rx),
    .m_data_tdata(tdata), .m_data_tvalid(tvalid), .m_data_tready(tready),
    .frame_err(ferr), .overrun(ovr)
  );
  always #5 aclk = ~aclk;
  int errors = 0, checks = 0;
  int cyc = 0, ferr_cnt = 0, ovr_cnt = 0, both_cnt = 0, hold_viol = 0, vcyc = 0, rise_cyc = -1;
  logic [7:0] got[$];
  logic pv = 1'b0, prdy = 1'b0;
  logic [7:0] pd = '0;
  always @(negedge aclk) begin
    cyc++;
    if (tvalid && tready) got.push_back(tdata);
    if (ferr) ferr_cnt++;
    if (ovr) ovr_cnt++;
    if (ferr && ovr) both_cnt++;
    if (tvalid) vcyc++;
    if (tvalid && !pv) rise_cyc = cyc;
    if (pv && !prdy && !arst && (tvalid !== 1'b1 || tdata !== pd)) hold_viol++;
    pv = tvalid; pd = tdata; prdy = tready;
  end
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) begin @(posedge aclk); #1; end
  endtask
  task automatic send(input logic [7:0] d, input logic stop_v, input logic pflip);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    if (PB == 1) drive(^d ^ pflip, CPB);
    drive(stop_v, CPB);
    rx = 1'b1;
  endtask
  task automatic test_reset;
    arst = 1'b1;
    drive(1'b1, 5);
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got=%h exp=00", tdata); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", ferr); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
    arst = 1'b0;
    drive(1'b1, 20);
  endtask
  task automatic test_single;
    int b, f0, o0, v0, st, lat_exp;
    b = got.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcyc; st = cyc;
    lat_exp = 2 + (1 + 8 + PB) * CPB + CPB / 2 + 1;
    send(8'h11, 1'b1, 1'b0);
    drive(1'b1, 200);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", got.size() - b); end
    else begin checks++; if (got[b] !== 8'h11) begin errors++; $display("FAIL single_data got=%h exp=11", got[b]); end end
    checks++; if (vcyc - v0 != 1) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=1", vcyc - v0); end
    checks++; if (rise_cyc - st < lat_exp - 2 || rise_cyc - st > lat_exp + 2) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", rise_cyc - st, lat_exp); end
    checks++; if (ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL single_flags got=%0d/%0d exp=0/0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask
  task automatic test_random_frames;
    logic [7:0] exp[$];
    logic [7:0] d;
    int b;
    b = got.size();
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      exp.push_back(d);
      send(d, 1'b1, 1'b0);
      drive(1'b1, $urandom_range(0, 300));
    end
    drive(1'b1, 200);
    checks++; if (got.size() - b != exp.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", got.size() - b, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[b+i] !== exp[i]) begin errors++; $display("FAIL random_data[%0d] got=%h exp=%h", i, got[b+i], exp[i]); end
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] exp[$];
    int b, o0;
    b = got.size(); o0 = ovr_cnt;
    exp = '{8'h11, 8'h12, 8'h13};
    for (int i = 0; i < 3; i++) exp.push_back(8'($urandom));
    foreach (exp[i]) send(exp[i], 1'b1, 1'b0);
    drive(1'b1, 200);
    checks++; if (got.size() - b != exp.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got.size() - b, exp.size()); end
    else for (int i = 0; i < exp.size(); i++) begin
      checks++; if (got[b+i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got[b+i], exp[i]); end
    end
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_cnt - o0); end
  endtask
  task automatic test_overrun;
    int b, o0, h0;
    b = got.size(); o0 = ovr_cnt; h0 = hold_viol;
    tready = 1'b0;
    send(8'hA5, 1'b1, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    drive(1'b1, 100);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ovr_tvalid_held got=%b exp=1", tvalid); end
    checks++; if (tdata !== 8'hA5) begin errors++; $display("FAIL ovr_tdata_held got=%h exp=a5", tdata); end
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); end
    tready = 1'b1;
    drive(1'b1, 10);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL ovr_transfers got=%0d exp=1", got.size() - b); end
    else begin checks++; if (got[b] !== 8'hA5) begin errors++; $display("FAIL ovr_data got=%h exp=a5", got[b]); end end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ovr_tvalid_cleared got=%b exp=0", tvalid); end
    checks++; if (hold_viol != h0) begin errors++; $display("FAIL ovr_axis_hold got=%0d exp=0", hold_viol - h0); end
  endtask
  task automatic test_frame_err;
    int b, f0, v0;
    b = got.size(); f0 = ferr_cnt; v0 = vcyc;
    send(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 2000);
    drive(1'b1, 50);
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", ferr_cnt - f0); end
    checks++; if (vcyc != v0) begin errors++; $display("FAIL ferr_no_valid got=%0d exp=0", vcyc - v0); end
    send(8'h3C, 1'b1, 1'b0);
    drive(1'b1, 100);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL ferr_next_count got=%0d exp=1", got.size() - b); end
    else begin checks++; if (got[b] !== 8'h3C) begin errors++; $display("FAIL ferr_next_data got=%h exp=3c", got[b]); end end
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL flags_same_cycle got=%0d exp=0", both_cnt); end
  endtask
  task automatic test_glitch;
    int b, f0, o0, v0;
    logic [7:0] d;
    b = got.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcyc;
    drive(1'b0, 30);
    drive(1'b1, 300);
    checks++; if (vcyc != v0 || ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL glitch_quiet got=%0d/%0d/%0d exp=0/0/0", vcyc - v0, ferr_cnt - f0, ovr_cnt - o0); end
    d = 8'($urandom);
    send(d, 1'b1, 1'b0);
    drive(1'b1, 100);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", got.size() - b); end
    else begin checks++; if (got[b] !== d) begin errors++; $display("FAIL glitch_next_data got=%h exp=%h", got[b], d); end end
  endtask
  task automatic test_reset_mid;
    int b, f0, o0, v0;
    logic [7:0] d;
    b = got.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcyc;
    d = 8'h77;
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(d[i], CPB);
    drive(d[4], CPB / 2);
    arst = 1'b1;
    drive(d[4], 3);
    arst = 1'b0;
    drive(1'b1, 1200);
    checks++; if (vcyc != v0 || ferr_cnt != f0 || ovr_cnt != o0) begin errors++; $display("FAIL rstmid_quiet got=%0d/%0d/%0d exp=0/0/0", vcyc - v0, ferr_cnt - f0, ovr_cnt - o0); end
    send(8'h78, 1'b1, 1'b0);
    drive(1'b1, 100);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", got.size() - b); end
    else begin checks++; if (got[b] !== 8'h78) begin errors++; $display("FAIL rstmid_next_data got=%h exp=78", got[b]); end end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int b, f0;
    b = got.size(); f0 = ferr_cnt;
    send(8'h07, 1'b1, 1'b0);
    drive(1'b1, 100);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL parity_ok_count got=%0d exp=1", got.size() - b); end
    else begin checks++; if (got[b] !== 8'h07) begin errors++; $display("FAIL parity_ok_data got=%h exp=07", got[b]); end end
    send(8'h07, 1'b1, 1'b1);
    drive(1'b1, 100);
    checks++; if (got.size() - b != 1) begin errors++; $display("FAIL parity_bad_count got=%0d exp=1", got.size() - b); end
    checks++; if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL parity_bad_ferr got=%0d exp=1", ferr_cnt - f0); end
  endtask
`endif
  initial begin
    @(posedge aclk); #1;
    test_reset;
    test_single;
    test_random_frames;
    test_back_to_back;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_reset_mid;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
